sgf_mult_round_norm: RTL

// - Pipelined post-multiplier stage; sits directly downstream of the Karatsuba significand multiplier.
// - Takes the raw 2*SW-bit product of two normalized significands, in [1,4).
// - Normalizes it to SW bits and applies IEEE-754 rounding (4 modes).
// - Reports exponent adjustment and the inexact flag to the exponent/flag logic.
// - Valid/ready handshake on both sides; 2-stage pipeline with full backpressure.

---
 rtl/sgf_mult_round_norm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sgf_mult_round_norm.sv
// sgf_mult_round_norm
// Post-multiplier normalize-and-round stage for IEEE-754 significands.
// Accepts the raw 2*SW-bit product of two normalized significands (value in
// [1,4)). It normalizes the product to SW bits and rounds it in one of four
// modes. It also reports the exponent adjustment and the inexact flag.
//
// Pipeline: stage 1 registers the normalized fields. Stage 2 registers the
// rounded result, which drives the outputs directly. A result therefore
// appears two cycles after the cycle in which its input was accepted.
//
// Handshake (valid/ready, both sides):
//   - A transfer happens on a rising clock edge where valid and ready are
//     both high. The producer must hold valid and data until that edge.
//   - out_valid_o/sgf_o/exp_adj_o/inexact_o stay stable while out_valid_o=1
//     and out_ready_i=0.
//   - s2_advance = !s2_valid | out_ready_i : stage 2 can take new data.
//   - in_ready_o = !s1_valid | s2_advance  : stage 1 can take new data.
//   - in_ready_o depends only on registered state and out_ready_i, never on
//     in_valid_i. This gives full throughput with no bubble when the input
//     is accepted and the output drains in the same cycle.
module sgf_mult_round_norm #(
    parameter int SW = 53
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2*SW-1:0] product_i,
    input  logic [1:0]      r_mode_i,
    input  logic            sign_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [SW-1:0]   sgf_o,
    output logic [1:0]      exp_adj_o,
    output logic            inexact_o
);

    // Rounding mode encodings
    localparam logic [1:0] RM_NEAREST_EVEN = 2'b00;
    localparam logic [1:0] RM_TOWARD_ZERO  = 2'b01;
    localparam logic [1:0] RM_TOWARD_POS   = 2'b10;
    localparam logic [1:0] RM_TOWARD_NEG   = 2'b11;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_advance;
    logic s1_accept;

    assign s2_advance  = !s2_valid || out_ready_i;
    assign in_ready_o  = !s1_valid || s2_advance;
    assign s1_accept   = in_valid_i && in_ready_o;
    assign out_valid_o = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1 combinational: normalization of the incoming product
    // ------------------------------------------------------------------
    logic [SW-1:0] norm_m;
    logic          norm_g;
    logic          norm_s;
    logic          norm_e;

    // Choose the window from the product MSB. The [2,4) range shifts right by one.
    always_comb begin
        norm_m = '0;
        norm_g = 1'b0;
        norm_s = 1'b0;
        norm_e = 1'b0;
        if (product_i[2*SW-1]) begin
            norm_m = product_i[2*SW-1:SW];
            norm_g = product_i[SW-1];
            norm_s = |product_i[SW-2:0];
            norm_e = 1'b1;
        end else begin
            // Also covers out-of-range products with both top bits clear.
            // These simply take the [1,2) path.
            norm_m = product_i[2*SW-2:SW-1];
            norm_g = product_i[SW-2];
            norm_s = |product_i[SW-3:0];
            norm_e = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [SW-1:0] s1_m;
    logic          s1_g;
    logic          s1_s;
    logic          s1_e;
    logic [1:0]    s1_mode;
    logic          s1_sign;

    // Capture normalized fields on accept. Hold them while stage 2 is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_m     <= '0;
            s1_g     <= 1'b0;
            s1_s     <= 1'b0;
            s1_e     <= 1'b0;
            s1_mode  <= RM_NEAREST_EVEN;
            s1_sign  <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (s1_accept) begin
                s1_m    <= norm_m;
                s1_g    <= norm_g;
                s1_s    <= norm_s;
                s1_e    <= norm_e;
                s1_mode <= r_mode_i;
                s1_sign <= sign_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: rounding increment and carry-out handling
    // ------------------------------------------------------------------
    logic          round_inc;
    logic [SW:0]   round_sum;
    logic [SW-1:0] round_sgf;
    logic [1:0]    round_adj;
    logic          round_inexact;

    // Pick the increment for the active mode.
    // The directed modes only round up in magnitude when moving away from zero.
    always_comb begin
        round_inc = 1'b0;
        case (s1_mode)
            RM_NEAREST_EVEN: round_inc = s1_g && (s1_s || s1_m[0]);
            RM_TOWARD_ZERO:  round_inc = 1'b0;
            RM_TOWARD_POS:   round_inc = !s1_sign && (s1_g || s1_s);
            RM_TOWARD_NEG:   round_inc =  s1_sign && (s1_g || s1_s);
            default:         round_inc = 1'b0;
        endcase
    end

    // Add on SW+1 bits. A carry out means the significand was all ones.
    // It becomes 1.000... and the exponent gains one more step.
    always_comb begin
        round_sum     = {1'b0, s1_m} + {{SW{1'b0}}, round_inc};
        round_sgf     = round_sum[SW-1:0];
        round_adj     = {1'b0, s1_e};
        round_inexact = s1_g || s1_s;
        if (round_sum[SW]) begin
            round_sgf = {1'b1, {(SW-1){1'b0}}};
            round_adj = {1'b0, s1_e} + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs)
    // ------------------------------------------------------------------
    // Advance when empty or drained. Otherwise hold the result stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            sgf_o     <= '0;
            exp_adj_o <= 2'd0;
            inexact_o <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sgf_o     <= round_sgf;
                exp_adj_o <= round_adj;
                inexact_o <= round_inexact;
            end
        end
    end

endmodule
